// File: rtl/hazard_unit_bp.sv
// Load-use/RAW hazard detection with a 2-bit-counter branch predictor and a
// fixed two-stage branch tracker that flags mispredictions at resolve time.
module hazard_unit_bp #(
  parameter int IW        = 16,
  parameter int OPW       = 3,
  parameter int RAW       = 3,
  parameter int RTYPE_OP  = 0,
  parameter int BEQ_OP    = 2,
  parameter int BHT_DEPTH = 4,
  parameter int PCW       = 8,
  parameter int IGNORE_R0 = 1,
  parameter int CNTW      = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IW-1:0]   ifid_instr,
  input  logic [PCW-1:0]  ifid_pc,
  input  logic [IW-1:0]   idex_instr,
  input  logic [IW-1:0]   exmem_instr,
  input  logic            idex_write,
  input  logic            exmem_write,
  input  logic            idex_regdst,
  input  logic            exmem_regdst,
  input  logic            br_taken,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            idex_bubble,
  output logic            predict_taken,
  output logic            mispredict,
  output logic            flush,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int IDXW = $clog2(BHT_DEPTH);
  localparam int RS_HI = IW - OPW - 1;
  localparam int RT_HI = IW - OPW - RAW - 1;
  localparam int RD_HI = IW - OPW - 2 * RAW - 1;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
    logic            pred;
  } slot_t;

  logic [OPW-1:0]  ifid_op;
  logic [RAW-1:0]  ifid_rs, ifid_rt;
  logic            two_src, is_beq;
  logic [RAW-1:0]  idex_dest, exmem_dest;
  logic            haz_idex, haz_exmem, stall;
  logic [IDXW-1:0] ifid_idx;
  logic [1:0]      bht [BHT_DEPTH];
  slot_t           slot1, slot2;
  logic            unused_bits;

  function automatic logic [RAW-1:0] dest_of(input logic [IW-1:0] instr, input logic regdst);
    return regdst ? instr[RD_HI -: RAW] : instr[RT_HI -: RAW];
  endfunction

  function automatic logic hit(input logic write, input logic [RAW-1:0] dest,
                               input logic [RAW-1:0] rs, input logic [RAW-1:0] rt,
                               input logic use_rt);
    logic zero_skip;
    zero_skip = (IGNORE_R0 != 0) && (dest == '0);
    return write && !zero_skip && ((dest == rs) || (use_rt && (dest == rt)));
  endfunction

  assign ifid_op  = ifid_instr[IW-1 -: OPW];
  assign ifid_rs  = ifid_instr[RS_HI -: RAW];
  assign ifid_rt  = ifid_instr[RT_HI -: RAW];
  assign two_src  = (ifid_op == OPW'(RTYPE_OP)) || (ifid_op == OPW'(BEQ_OP));
  assign is_beq   = (ifid_op == OPW'(BEQ_OP));
  assign ifid_idx = ifid_pc[IDXW-1:0];

  assign idex_dest  = dest_of(idex_instr, idex_regdst);
  assign exmem_dest = dest_of(exmem_instr, exmem_regdst);
  assign haz_idex   = hit(idex_write, idex_dest, ifid_rs, ifid_rt, two_src);
  assign haz_exmem  = hit(exmem_write, exmem_dest, ifid_rs, ifid_rt, two_src);

  assign mispredict = slot2.valid && (br_taken != slot2.pred);
  assign flush      = mispredict;
  assign stall      = (haz_idex || haz_exmem) && !flush;

  assign pc_stall      = stall || !reset;
  assign ifid_stall    = stall;
  assign idex_bubble   = stall;
  assign predict_taken = is_beq && bht[ifid_idx][1];

  assign unused_bits = ^{ifid_instr, ifid_pc, idex_instr, exmem_instr};

  // A flush squashes slot1 as it shifts, so a wrong-path branch never resolves.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot1 <= '0;
      slot2 <= '0;
    end else begin
      slot1 <= '{valid: is_beq && !stall && !flush, idx: ifid_idx, pred: predict_taken};
      slot2 <= flush ? '0 : slot1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (slot2.valid) begin
      if (br_taken && bht[slot2.idx] != 2'b11)
        bht[slot2.idx] <= bht[slot2.idx] + 2'b01;
      else if (!br_taken && bht[slot2.idx] != 2'b00)
        bht[slot2.idx] <= bht[slot2.idx] - 2'b01;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_hazard_unit_bp.sv
// Bench for hazard_unit_bp: table of hazard vectors plus branch-predictor
// sequences, expectations queued at drive time and checked before the next edge.
module tb_hazard_unit_bp;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ifid_instr, idex_instr, exmem_instr;
  logic [7:0]  ifid_pc;
  logic        idex_write, exmem_write, idex_regdst, exmem_regdst, br_taken;
  logic        pc_stall, ifid_stall, idex_bubble, predict_taken, mispredict, flush;
  logic [15:0] stall_cnt;
  logic        r0_pc_stall, r0_ifid_stall, r0_idex_bubble, r0_predict_taken, r0_mispredict, r0_flush;
  logic [1:0]  r0_stall_cnt;

  always #5 clock = ~clock;

  hazard_unit_bp dut (
    .clock(clock), .reset(reset), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .idex_instr(idex_instr), .exmem_instr(exmem_instr), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_regdst(idex_regdst), .exmem_regdst(exmem_regdst),
    .br_taken(br_taken), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_bubble(idex_bubble), .predict_taken(predict_taken), .mispredict(mispredict),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  hazard_unit_bp #(.IGNORE_R0(0), .CNTW(2)) u_r0 (
    .clock(clock), .reset(reset), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .idex_instr(idex_instr), .exmem_instr(exmem_instr), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_regdst(idex_regdst), .exmem_regdst(exmem_regdst),
    .br_taken(br_taken), .pc_stall(r0_pc_stall), .ifid_stall(r0_ifid_stall),
    .idex_bubble(r0_idex_bubble), .predict_taken(r0_predict_taken),
    .mispredict(r0_mispredict), .flush(r0_flush), .stall_cnt(r0_stall_cnt)
  );

  typedef struct {
    logic [15:0] ifid, idex, exmem;
    logic        idw, idrd, exw, exrd;
    logic        st, st_r0;
  } vec_t;

  typedef struct {
    int          tag;
    logic        st, st_r0, pred, mis;
    bit          chk_cnt;
    logic [15:0] cnt;
    logic [1:0]  cnt_r0;
  } exp_t;

  vec_t        tbl [12];
  exp_t        sb [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          tag = 0;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt_r0;

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [2:0] rd);
    return {op, rs, rt, rd, 4'b0000};
  endfunction

  localparam logic [15:0] NOP = 16'h3400;  // opcode 1, rs=5
  localparam logic [15:0] BEQ = 16'h4500;  // opcode 2, rs=1, rt=2

  task automatic chk(input string nm, input int t, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got %0h, expected %0h", nm, t, act, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: empty queue, got 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    chk("pc_stall", e.tag, {15'd0, pc_stall}, {15'd0, e.st});
    chk("ifid_stall", e.tag, {15'd0, ifid_stall}, {15'd0, e.st});
    chk("idex_bubble", e.tag, {15'd0, idex_bubble}, {15'd0, e.st});
    chk("predict_taken", e.tag, {15'd0, predict_taken}, {15'd0, e.pred});
    chk("mispredict", e.tag, {15'd0, mispredict}, {15'd0, e.mis});
    chk("flush", e.tag, {15'd0, flush}, {15'd0, e.mis});
    chk("r0_stall", e.tag, {15'd0, r0_idex_bubble}, {15'd0, e.st_r0});
    if (e.chk_cnt) begin
      chk("stall_cnt", e.tag, stall_cnt, e.cnt);
      chk("r0_stall_cnt", e.tag, {14'd0, r0_stall_cnt}, {14'd0, e.cnt_r0});
    end
  endtask

  task automatic step(input logic [15:0] instr, input logic [7:0] pc, input logic taken,
                      input logic haz, input logic exp_pred, input logic exp_mis);
    exp_t e;
    @(posedge clock); #1;
    ifid_instr = instr; ifid_pc = pc; br_taken = taken;
    idex_instr = mk(3'd0, 3'd0, 3'd0, 3'd5); idex_write = haz; idex_regdst = 1'b1;
    exmem_instr = '0; exmem_write = 1'b0; exmem_regdst = 1'b0;
    tag++;
    e = '{tag: tag, st: haz & ~exp_mis, st_r0: haz & ~exp_mis, pred: exp_pred, mis: exp_mis,
          chk_cnt: 1'b0, cnt: 16'd0, cnt_r0: 2'd0};
    sb.push_back(e);
    @(negedge clock);
    compare();
  endtask

  task automatic branch(input logic [7:0] pc, input logic taken, input logic exp_pred,
                        input logic exp_mis, input logic haz);
    step(BEQ, pc, 1'b0, 1'b0, exp_pred, 1'b0);
    step(NOP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NOP, 8'd0, taken, haz, 1'b0, exp_mis);
  endtask

  task automatic quiet();
    ifid_instr = NOP; ifid_pc = '0; br_taken = 1'b0;
    idex_instr = '0; exmem_instr = '0;
    idex_write = 1'b0; exmem_write = 1'b0; idex_regdst = 1'b0; exmem_regdst = 1'b0;
  endtask

  task automatic check_reset_state(input int t);
    chk("rst_pc_stall", t, {15'd0, pc_stall}, 16'd1);
    chk("rst_ifid_stall", t, {15'd0, ifid_stall}, 16'd0);
    chk("rst_mispredict", t, {15'd0, mispredict}, 16'd0);
    chk("rst_flush", t, {15'd0, flush}, 16'd0);
    chk("rst_stall_cnt", t, stall_cnt, 16'd0);
    chk("rst_predict", t, {15'd0, predict_taken}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    quiet();
    #1 reset = 1'b0;
    #1 check_reset_state(0);
    #10 reset = 1'b1;

    tbl[0]  = '{mk(0,3,1,0), mk(0,0,0,3), 16'd0,       1,1,0,0, 1,1};
    tbl[1]  = '{mk(0,3,1,0), mk(0,0,0,3), 16'd0,       1,1,0,0, 1,1};
    tbl[2]  = '{mk(0,3,1,0), mk(0,0,3,5), 16'd0,       1,0,0,0, 1,1};
    tbl[3]  = '{mk(0,2,5,0), mk(0,0,0,2), 16'd0,       0,1,0,0, 0,0};
    tbl[4]  = '{mk(1,2,4,0), 16'd0,       mk(0,0,4,0), 0,0,1,0, 0,0};
    tbl[5]  = '{mk(0,2,4,0), 16'd0,       mk(0,0,4,0), 0,0,1,0, 1,1};
    tbl[6]  = '{mk(2,1,6,0), 16'd0,       mk(0,0,0,6), 0,0,1,1, 1,1};
    tbl[7]  = '{mk(3,0,0,0), 16'd0,       mk(0,0,0,0), 0,0,1,1, 0,1};
    tbl[8]  = '{mk(0,0,0,0), mk(0,0,0,0), 16'd0,       1,0,0,0, 0,1};
    tbl[9]  = '{mk(4,7,7,0), mk(0,0,0,7), 16'd0,       1,1,0,0, 1,1};
    tbl[10] = '{mk(0,1,2,0), mk(0,0,0,1), mk(0,0,2,0), 1,1,1,0, 1,1};
    tbl[11] = '{mk(0,1,2,0), 16'd0,       16'd0,       0,0,0,0, 0,0};

    m_cnt = '0;
    m_cnt_r0 = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      ifid_instr = tbl[i].ifid; ifid_pc = '0; br_taken = 1'b0;
      idex_instr = tbl[i].idex; idex_write = tbl[i].idw; idex_regdst = tbl[i].idrd;
      exmem_instr = tbl[i].exmem; exmem_write = tbl[i].exw; exmem_regdst = tbl[i].exrd;
      tag++;
      e = '{tag: tag, st: tbl[i].st, st_r0: tbl[i].st_r0, pred: 1'b0, mis: 1'b0,
            chk_cnt: 1'b1, cnt: m_cnt, cnt_r0: m_cnt_r0};
      sb.push_back(e);
      @(negedge clock);
      compare();
      m_cnt = m_cnt + {15'd0, tbl[i].st};
      if (tbl[i].st_r0 && m_cnt_r0 != 2'd3) m_cnt_r0 = m_cnt_r0 + 2'd1;
    end

    @(posedge clock); #1;
    quiet();
    reset = 1'b0;
    @(negedge clock);
    check_reset_state(100);
    @(posedge clock); #1;
    reset = 1'b1;

    // Cold miss at index 2 trains it to weakly taken; flush hides a hazard stall.
    branch(8'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    step(NOP, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    branch(8'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    // Back-to-back branches at index 3: the second is squashed by the first's flush.
    step(BEQ, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(BEQ, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(NOP, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(NOP, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    branch(8'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    branch(8'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation at index 1 (pc 5 aliases to index 1).
    branch(8'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) branch(8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    branch(8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    branch(8'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset while a branch sits in slot1.
    step(BEQ, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    ifid_instr = BEQ; ifid_pc = 8'd2; br_taken = 1'b1;
    @(negedge clock);
    check_reset_state(200);
    @(posedge clock); #1;
    @(negedge clock);
    check_reset_state(201);
    @(posedge clock); #1;
    reset = 1'b1;
    ifid_instr = NOP;
    @(negedge clock);
    chk("post_rst_mispredict", 202, {15'd0, mispredict}, 16'd0);
    step(NOP, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(NOP, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    branch(8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("scoreboard_drained", 300, 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_bp.md
HAZARD_UNIT_BP -- requirements
Module: hazard_unit_bp

Interface
REQ-001 SHALL have parameter IW, default 16, instruction width.
REQ-002 SHALL have parameter OPW, default 3, opcode width at instr[IW-1:IW-OPW].
REQ-003 SHALL have parameter RAW, default 3, register address width: rs, rt and rd in consecutive RAW-bit fields directly below the opcode (16-bit defaults: rs 12:10, rt 9:7, rd 6:4).
REQ-004 SHALL have parameter RTYPE_OP, default 0, opcode of the two-source R-type format.
REQ-005 SHALL have parameter BEQ_OP, default 2, branch opcode.
REQ-006 SHALL have parameter BHT_DEPTH, default 4, predictor entries; power of two >= 2.
REQ-007 SHALL have parameter PCW, default 8, PC index input width; PCW >= log2(BHT_DEPTH).
REQ-008 SHALL have parameter IGNORE_R0, default 1; when 1, writes to register 0 never cause a hazard.
REQ-009 SHALL have parameter CNTW, default 16, stall counter width.
REQ-010 clock  in  1  sole clock, rising edge.
REQ-011 reset  in  1  asynchronous, active-low reset.
REQ-012 ifid_instr  in  IW  instruction in IF/ID.
REQ-013 ifid_pc  in  PCW  PC of the IF/ID instruction.
REQ-014 idex_instr, exmem_instr  in  IW  instructions in ID/EX and EX/MEM.
REQ-015 idex_write, exmem_write  in  1  stage writes a register.
REQ-016 idex_regdst, exmem_regdst  in  1  destination select: 0 = rt, 1 = rd.
REQ-017 br_taken  in  1  actual branch outcome; valid while the branch is in the resolve slot.
REQ-018 pc_stall, ifid_stall, idex_bubble  out  1  hold PC, hold IF/ID, insert bubble in ID/EX.
REQ-019 predict_taken  out  1  prediction for the IF/ID branch.
REQ-020 mispredict, flush  out  1  resolved branch disagrees with its prediction.
REQ-021 stall_cnt  out  CNTW  count of stalled cycles.

Function
REQ-022 A stage's destination SHALL be rd when regdst=1, else rt.
REQ-023 Source registers SHALL be rs for all opcodes, plus rt when opcode is RTYPE_OP or BEQ_OP.
REQ-024 A stage SHALL be hazardous when its write=1 and its destination equals any source register, excluding destination 0 when IGNORE_R0=1.
REQ-025 Stall condition (hazardous(ID/EX) OR hazardous(EX/MEM)) AND NOT flush SHALL be combinational, same cycle, with no registered delay.
REQ-026 pc_stall, ifid_stall and idex_bubble SHALL each equal the stall condition, except that pc_stall SHALL be 1 while reset is low.
REQ-027 The branch history table SHALL hold BHT_DEPTH 2-bit saturating counters, indexed by ifid_pc[log2(BHT_DEPTH)-1:0].
REQ-028 predict_taken SHALL be the MSB of the indexed counter when the IF/ID opcode is BEQ_OP, else 0; it is combinational.
REQ-029 The tracker SHALL be a 2-slot shift of {valid, index, prediction}.
REQ-030 On each edge, slot1 SHALL load valid = (IF/ID opcode is BEQ_OP AND no stall AND no flush), and slot2 SHALL load slot1.
REQ-031 The tracker SHALL give a fixed 2-cycle latency from branch capture to resolve.
REQ-032 mispredict SHALL be combinational: slot2.valid AND (br_taken != slot2.prediction); flush SHALL equal mispredict.
REQ-033 On the edge leaving a valid slot2, the counter at slot2.index SHALL increment when br_taken=1 and decrement when br_taken=0, saturating at 3 and 0.
REQ-034 Simultaneous update and lookup of the same index SHALL give the pre-update value to the lookup.
REQ-035 When flush=1, slot1 SHALL become invalid at the next edge, squashing the wrong-path branch.
REQ-036 stall_cnt SHALL increment on each edge where the stall condition is 1, saturating at all-ones.

Reset
REQ-037 While reset is low: all BHT counters = 2'b01, both slots invalid, stall_cnt = 0, mispredict = flush = 0, pc_stall = 1.
REQ-038 Reset asserted mid-operation SHALL discard in-flight branches without any BHT update.

Verification
REQ-039 IF/ID R-type rs=3; ID/EX write=1, regdst=1, rd=3 -> pc_stall = ifid_stall = idex_bubble = 1 the same cycle; stall_cnt += 1 per cycle.
REQ-040 Only EX/MEM write=1, dest=0; IF/ID source 0; IGNORE_R0=1 -> no stall; repeat with IGNORE_R0=0 -> stall.
REQ-041 BEQ at pc=2 after reset -> predict_taken=0; br_taken=1 two cycles later -> mispredict = flush = 1 for one cycle; counter[2] = 2'b10; next BEQ at pc=2 -> predict_taken=1.
REQ-042 Two back-to-back BEQs with the first mispredicted -> second squashed: no mispredict and no BHT update for it.
REQ-043 Four taken resolutions at one index -> counter saturates at 3; fifth taken -> still 3, no mispredict.
REQ-044 Reset pulsed low while slot1 is valid -> all outputs and BHT return to reset values; no mispredict after release.
